// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared mode encodings for the LED blink array
package led_blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   function automatic logic is_active(input mode_e m);
      return (m == MODE_BLINK) || (m == MODE_BURST);
   endfunction

endpackage

// File: rtl/led_blink_channel.sv
// rtl/led_blink_channel.sv - one LED channel: mode, phase and burst state with registered outputs
module led_blink_channel
   import led_blink_pkg::*;
#(
   parameter int PER_W   = 16,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_i,
   input  logic               load_i,
   input  mode_e              mode_i,
   input  logic [PER_W-1:0]   half_period_i,
   input  logic [BURST_W-1:0] burst_i,
   output logic               led_o,
   output logic               busy_o,
   output logic               done_o
);

   mode_e              mode_q;
   logic [PER_W-1:0]   half_q;
   logic [PER_W-1:0]   phase_q;
   logic [BURST_W-1:0] rem_q;
   logic               led_q;
   logic               busy_q;
   logic               done_q;
   logic [PER_W-1:0]   last_phase;

   // A stored half-period of 0 behaves exactly like 1.
   assign last_phase = (half_q == '0) ? '0 : half_q - PER_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_OFF;
         half_q  <= '0;
         phase_q <= '0;
         rem_q   <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_i) begin
            mode_q  <= mode_i;
            half_q  <= half_period_i;
            rem_q   <= burst_i;
            phase_q <= '0;
            unique case (mode_i)
               MODE_OFF: begin
                  led_q  <= 1'b0;
                  busy_q <= 1'b0;
               end
               MODE_ON: begin
                  led_q  <= 1'b1;
                  busy_q <= 1'b0;
               end
               MODE_BLINK: begin
                  led_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
               MODE_BURST: begin
                  if (burst_i == '0) begin
                     mode_q <= MODE_OFF;
                     led_q  <= 1'b0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     led_q  <= 1'b1;
                     busy_q <= 1'b1;
                  end
               end
            endcase
         end else if (tick_i && is_active(mode_q)) begin
            if (phase_q == last_phase) begin
               phase_q <= '0;
               // A burst cycle is consumed on each falling (1->0) LED edge.
               if ((mode_q == MODE_BURST) && led_q) begin
                  led_q <= 1'b0;
                  if (rem_q <= BURST_W'(1)) begin
                     mode_q <= MODE_OFF;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     rem_q  <= '0;
                  end else begin
                     rem_q <= rem_q - BURST_W'(1);
                  end
               end else begin
                  led_q <= ~led_q;
               end
            end else begin
               phase_q <= phase_q + PER_W'(1);
            end
         end
      end
   end

   assign led_o  = led_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: rtl/led_blink_array.sv
// rtl/led_blink_array.sv - multi-channel LED blink controller with shared tick prescaler
module led_blink_array
   import led_blink_pkg::*;
#(
   parameter int  N_CH     = 4,
   parameter int  TICK_DIV = 50000,
   parameter int  PER_W    = 16,
   parameter int  BURST_W  = 4,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [CH_W-1:0]    wr_ch,
   input  logic [1:0]         wr_mode,
   input  logic [PER_W-1:0]   wr_half_period,
   input  logic [BURST_W-1:0] wr_burst,
   output logic [N_CH-1:0]    led,
   output logic [N_CH-1:0]    busy,
   output logic [N_CH-1:0]    done
);

   localparam int              PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick;
   logic             wr_accept;

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   // Out-of-range channel numbers are dropped so they cannot alias a real channel.
   assign wr_accept = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(N_CH));

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      led_blink_channel #(
         .PER_W   (PER_W),
         .BURST_W (BURST_W)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .tick_i        (tick),
         .load_i        (wr_accept && (wr_ch == CH_W'(g))),
         .mode_i        (mode_e'(wr_mode)),
         .half_period_i (wr_half_period),
         .burst_i       (wr_burst),
         .led_o         (led[g]),
         .busy_o        (busy[g]),
         .done_o        (done[g])
      );
   end

endmodule

// File: tb/tb_led_blink_array.sv
// tb/tb_led_blink_array.sv - randomized model-checked bench for led_blink_array (4- and 3-channel builds)
module tb_led_blink_array;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_ch;
   logic [1:0] wr_mode;
   logic [7:0] wr_half_period;
   logic [3:0] wr_burst;
   logic [3:0] led_a, busy_a, done_a;
   logic [2:0] led_b, busy_b, done_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_blink_array #(.N_CH(4), .TICK_DIV(TD), .PER_W(8), .BURST_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
      .wr_half_period(wr_half_period), .wr_burst(wr_burst),
      .led(led_a), .busy(busy_a), .done(done_a)
   );

   led_blink_array #(.N_CH(3), .TICK_DIV(TD), .PER_W(8), .BURST_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
      .wr_half_period(wr_half_period), .wr_burst(wr_burst),
      .led(led_b), .busy(busy_b), .done(done_b)
   );

   // Model: each channel remembers how many ticks it has seen since its last write;
   // the LED level and burst end follow from that count by division.
   typedef struct packed {
      int   mode;
      int   h;
      int   n;
      int   t;
      logic dn;
   } ch_t;

   ch_t m [2][4];
   int  m_cyc;

   function automatic int nch(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic ch_t step(input ch_t s, input logic hit, input logic tk,
                                input int wm, input int whp, input int wb);
      ch_t r = s;
      r.dn = 1'b0;
      if (hit) begin
         r.mode = wm;
         r.h    = (whp == 0) ? 1 : whp;
         r.n    = wb;
         r.t    = 0;
         if (wm == 3 && wb == 0) begin
            r.mode = 0;
            r.dn   = 1'b1;
         end
      end else if (tk && (s.mode == 2 || s.mode == 3)) begin
         r.t = s.t + 1;
         if (s.mode == 3 && (r.t / s.h) >= 2 * s.n - 1) begin
            r.mode = 0;
            r.dn   = 1'b1;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc <= 0;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
               m[d][c] <= '{mode: 0, h: 1, n: 0, t: 0, dn: 1'b0};
      end else begin
         m_cyc <= m_cyc + 1;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
               m[d][c] <= step(m[d][c],
                               wr_en && (int'(wr_ch) == c) && (c < nch(d)),
                               (m_cyc % TD) == TD - 1,
                               int'(wr_mode), int'(wr_half_period), int'(wr_burst));
      end
   end

   function automatic logic [3:0] exp_vec(input int d, input int kind);
      logic [3:0] v = '0;
      for (int c = 0; c < nch(d); c++) begin
         case (kind)
            0: v[c] = (m[d][c].mode == 1) ||
                      ((m[d][c].mode == 2 || m[d][c].mode == 3) &&
                       ((m[d][c].t / m[d][c].h) % 2 == 0));
            1: v[c] = (m[d][c].mode == 2 || m[d][c].mode == 3);
            default: v[c] = m[d][c].dn;
         endcase
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic adv();
      @(negedge clk);
      chk("a_led",  led_a,  exp_vec(0, 0));
      chk("a_busy", busy_a, exp_vec(0, 1));
      chk("a_done", done_a, exp_vec(0, 2));
      chk("b_led",  {1'b0, led_b},  exp_vec(1, 0));
      chk("b_busy", {1'b0, busy_b}, exp_vec(1, 1));
      chk("b_done", {1'b0, done_b}, exp_vec(1, 2));
   endtask

   task automatic wr(input int c, input int md, input int hp, input int b);
      wr_en          = 1'b1;
      wr_ch          = 2'(c);
      wr_mode        = 2'(md);
      wr_half_period = 8'(hp);
      wr_burst       = 4'(b);
      adv();
      wr_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0;
      wr_ch = '0;
      wr_mode = '0;
      wr_half_period = '0;
      wr_burst = '0;
      repeat (2) @(negedge clk);
      chk("reset_led",  led_a,  4'b0000);
      chk("reset_busy", busy_a, 4'b0000);
      chk("reset_done", done_a, 4'b0000);
      rst_n = 1'b1;

      // Directed timeline; comment numbers are the clock edge just completed.
      wr(2, 3, 1, 2);                                    // 1 BURST ch2 hp1 x2
      wr(1, 2, 3, 0);                                    // 2 BLINK ch1 hp3
      wr(0, 2, 0, 0);                                    // 3 BLINK ch0 hp0
      adv();                                             // 4 first tick
      chk("hp0_first_toggle", {3'b0, led_a[0]}, 4'd0);
      chk("burst_first_off",  {3'b0, led_a[2]}, 4'd0);
      repeat (4) adv();                                  // 8
      chk("hp0_second_toggle", {3'b0, led_a[0]}, 4'd1);
      chk("burst_second_on",   {3'b0, led_a[2]}, 4'd1);
      wr(0, 1, 7, 3);                                    // 9 ch0 -> ON
      chk("on_after_blink", {2'b0, led_a[0], busy_a[0]}, 4'b0010);
      repeat (2) adv();                                  // 11
      chk("blink_hp3_still_on", {3'b0, led_a[1]}, 4'd1);
      adv();                                             // 12
      chk("burst_end", {1'b0, led_a[2], busy_a[2], done_a[2]}, 4'b0001);
      chk("blink_hp3_toggle", {3'b0, led_a[1]}, 4'd0);
      chk("on_no_done", {3'b0, done_a[0]}, 4'd0);
      wr(2, 2, 5, 0);                                    // 13
      chk("reblink_ch2", {1'b0, led_a[2], busy_a[2], done_a[2]}, 4'b0110);
      wr(2, 3, 4, 0);                                    // 14 BURST with count 0
      chk("burst0_done", {1'b0, led_a[2], busy_a[2], done_a[2]}, 4'b0001);
      adv();                                             // 15
      chk("burst0_pulse_end", {1'b0, led_a[2], busy_a[2], done_a[2]}, 4'b0000);
      wr(3, 2, 2, 0);                                    // 16 write on a tick edge
      repeat (7) adv();                                  // 23
      chk("tickwrite_hold", {2'b0, led_a[3], led_a[1]}, 4'b0010);
      adv();                                             // 24
      chk("tickwrite_toggle", {2'b0, led_a[3], led_a[1]}, 4'b0001);
      wr(3, 1, 0, 0);                                    // 25 ch3 ignored on 3-ch build
      chk("a_led_lit",  led_a,  4'b1011);
      chk("a_busy_lit", busy_a, 4'b0010);
      chk("b_led_lit",  {1'b0, led_b},  4'b0011);
      chk("b_busy_lit", {1'b0, busy_b}, 4'b0010);

      repeat (3000) begin
         if ($urandom_range(0, 3) == 0)
            wr($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));
         else
            adv();
      end

      // Asynchronous reset mid-cycle, then prove the prescaler restarts at 0.
      wr(0, 2, 1, 0);
      repeat (2) adv();
      #2 rst_n = 1'b0;
      #1;
      chk("async_led",  led_a,  4'b0000);
      chk("async_busy", busy_a, 4'b0000);
      chk("async_done", done_a, 4'b0000);
      chk("async_led_b", {1'b0, led_b}, 4'b0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr(0, 2, 0, 0);                                    // 1
      repeat (2) adv();                                  // 3
      chk("restart_before_tick", {3'b0, led_a[0]}, 4'd1);
      adv();                                             // 4
      chk("restart_first_tick", {3'b0, led_a[0]}, 4'd0);

      repeat (500) begin
         if ($urandom_range(0, 2) == 0)
            wr($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom_range(0, 2));
         else
            adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
